fifo_in_sequencer: RTL

Controller that drives the skewing input FIFO of the 16×16 systolic array. It accepts a stream of 32-bit activation words over a valid/ready handshake and issues the FIFO's load/push command sequence: three pre-register loads, then one push per 16-byte row. It counts rows per tile and, optionally, drains the 15-stage skew chain with zero rows. It sits between the host/DMA input port and the FIFO's `input0`/`command`/`col` pins.

---
 rtl/fifo_in_seq_pkg.sv | 21 ++
 rtl/fifo_in_sequencer.sv | 119 +++++++++++
 2 files changed

// File: rtl/fifo_in_seq_pkg.sv
// Shared command codes and state encoding for fifo_in_sequencer.
// The drain states exist only when FIFO_IN_SEQ_DRAIN_EN is defined.
package fifo_in_seq_pkg;

    localparam logic [1:0] CMD_IDLE = 2'b00;
    localparam logic [1:0] CMD_LOAD = 2'b01;
    localparam logic [1:0] CMD_PUSH = 2'b10;
    localparam logic [1:0] COL_PUSH = 2'd3;
    localparam int unsigned NUM_PRE_REGS = 3;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD       = 3'd1,
`ifdef FIFO_IN_SEQ_DRAIN_EN
        DRAIN_CLR  = 3'd2,
        DRAIN_PUSH = 3'd3,
`endif
        FINISH     = 3'd4
    } seq_state_t;

endpackage

// File: rtl/fifo_in_sequencer.sv
// Load/push command sequencer for the systolic array's skewing input FIFO.
// Define FIFO_IN_SEQ_DRAIN_EN to add the zero-row drain of the skew chain.
module fifo_in_sequencer #(
    parameter int unsigned SKEW_DEPTH = 15,
    parameter int unsigned ROW_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic [ROW_W-1:0] cfg_rows,
    input  logic [31:0]      s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [31:0]      fifo_data,
    output logic [1:0]       fifo_command,
    output logic [1:0]       fifo_col,
    output logic             busy,
    output logic             done,
    output logic [ROW_W-1:0] rows_done
);
    import fifo_in_seq_pkg::*;

    localparam logic [ROW_W-1:0] ROW_ONE = 1;

`ifdef FIFO_IN_SEQ_DRAIN_EN
    localparam int unsigned DRAIN_W = $clog2(SKEW_DEPTH + 1);
    localparam seq_state_t  TAIL_STATE = DRAIN_CLR;
    logic [DRAIN_W-1:0] drain_cnt;
`else
    localparam seq_state_t  TAIL_STATE = FINISH;
`endif

    seq_state_t       state;
    logic [1:0]       col;
    logic [ROW_W-1:0] cfg_q;

    assign s_ready = (state == LOAD);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            col          <= '0;
            cfg_q        <= '0;
            rows_done    <= '0;
            fifo_data    <= '0;
            fifo_command <= CMD_IDLE;
            fifo_col     <= '0;
            done         <= 1'b0;
`ifdef FIFO_IN_SEQ_DRAIN_EN
            drain_cnt    <= '0;
`endif
        end else begin
            fifo_command <= CMD_IDLE;
            done         <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cfg_q     <= cfg_rows;
                        rows_done <= '0;
                        col       <= '0;
                        state     <= (cfg_rows != '0) ? LOAD : TAIL_STATE;
                    end
`ifdef FIFO_IN_SEQ_DRAIN_EN
                    else if (flush) begin
                        col   <= '0;
                        state <= DRAIN_CLR;
                    end
`endif
                end
                LOAD: begin
                    // Without an accept the FIFO sees CMD_IDLE and holds; col stays put.
                    if (s_valid) begin
                        fifo_data    <= s_data;
                        fifo_col     <= col;
                        fifo_command <= (col == COL_PUSH) ? CMD_PUSH : CMD_LOAD;
                        col          <= col + 2'd1;
                        if (col == COL_PUSH) begin
                            if (rows_done != '1)
                                rows_done <= rows_done + ROW_ONE;
                            if (rows_done == cfg_q - ROW_ONE)
                                state <= TAIL_STATE;
                        end
                    end
                end
`ifdef FIFO_IN_SEQ_DRAIN_EN
                DRAIN_CLR: begin
                    fifo_data    <= '0;
                    fifo_col     <= col;
                    fifo_command <= CMD_LOAD;
                    if (col == 2'(NUM_PRE_REGS - 1)) begin
                        col       <= '0;
                        drain_cnt <= '0;
                        state     <= DRAIN_PUSH;
                    end else begin
                        col <= col + 2'd1;
                    end
                end
                DRAIN_PUSH: begin
                    fifo_data    <= '0;
                    fifo_col     <= COL_PUSH;
                    fifo_command <= CMD_PUSH;
                    if (drain_cnt == DRAIN_W'(SKEW_DEPTH - 1))
                        state <= FINISH;
                    else
                        drain_cnt <= drain_cnt + DRAIN_W'(1);
                end
`endif
                FINISH: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
